// File: rtl/cpu_operand_fetch.sv
// Operand fetch stage for the moxie 2-write/2-read register file.
// Drives the file's registered read ports, snoops both write ports so that
// operands never pick up a stale value across a read-during-write, keeps a
// busy scoreboard for long-latency destinations, and hands operand pairs to
// execute through a two-stage valid/ready pipeline (S1 = indices and
// forward capture, S2 = output register).
module cpu_operand_fetch #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int IDXW  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // decode side
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [IDXW-1:0]  req_ra_i,
    input  logic [IDXW-1:0]  req_rb_i,
    input  logic             req_use_ra_i,
    input  logic             req_use_rb_i,
    // scoreboard reservation
    input  logic             mark_busy_i,
    input  logic [IDXW-1:0]  mark_busy_index_i,
    // register file write port snoop
    input  logic             write_enable0_i,
    input  logic [IDXW-1:0]  reg_write_index0_i,
    input  logic [WIDTH-1:0] value0_i,
    input  logic             write_enable1_i,
    input  logic [IDXW-1:0]  reg_write_index1_i,
    input  logic [WIDTH-1:0] value1_i,
    // register file read ports
    output logic [IDXW-1:0]  reg_read_index0_o,
    output logic [IDXW-1:0]  reg_read_index1_o,
    input  logic [WIDTH-1:0] rf_value0_i,
    input  logic [WIDTH-1:0] rf_value1_i,
    // execute side
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o,
    output logic [NREGS-1:0] busy_o
);

    // Look up an index against both snooped write ports. Returns
    // {hit, data}; port 1 is checked last so it wins when both ports
    // target the same register.
    function automatic logic [WIDTH:0] snoop_lookup(
        input logic [IDXW-1:0]  idx,
        input logic             we0,
        input logic [IDXW-1:0]  wi0,
        input logic [WIDTH-1:0] wv0,
        input logic             we1,
        input logic [IDXW-1:0]  wi1,
        input logic [WIDTH-1:0] wv1
    );
        logic [WIDTH:0] res;
        res = '0;
        if (we0 && (wi0 == idx)) begin
            res = {1'b1, wv0};
        end
        if (we1 && (wi1 == idx)) begin
            res = {1'b1, wv1};
        end
        return res;
    endfunction

    // Per-operand views of the request and file data (0 = A, 1 = B)
    logic [IDXW-1:0]  req_idx  [2];
    logic [WIDTH-1:0] rf_value [2];

    assign req_idx[0]  = req_ra_i;
    assign req_idx[1]  = req_rb_i;
    assign rf_value[0] = rf_value0_i;
    assign rf_value[1] = rf_value1_i;

    // S1: accepted indices plus forward capture
    logic             s1_valid_q, s1_valid_d;
    logic [IDXW-1:0]  s1_idx_q      [2];
    logic [IDXW-1:0]  s1_idx_d      [2];
    logic             fwd_q         [2];
    logic             fwd_d         [2];
    logic [WIDTH-1:0] fwd_data_q    [2];
    logic [WIDTH-1:0] fwd_data_d    [2];

    // S2: output register and the indices the held operands came from
    logic             op_valid_q, op_valid_d;
    logic [WIDTH-1:0] op_q          [2];
    logic [WIDTH-1:0] op_d          [2];
    logic [IDXW-1:0]  s2_idx_q      [2];
    logic [IDXW-1:0]  s2_idx_d      [2];

    // Scoreboard
    logic [NREGS-1:0] busy_q, busy_d;

    // Pipeline handshake
    logic advance;
    logic hazard;
    logic accept;

    assign advance     = s1_valid_q && (!op_valid_q || op_ready_i);
    assign hazard      = (req_use_ra_i && busy_q[req_ra_i]) ||
                         (req_use_rb_i && busy_q[req_rb_i]);
    assign req_ready_o = !hazard && (!s1_valid_q || advance);
    assign accept      = req_valid_i && req_ready_o;

    // Per-operand combinational datapath
    logic [IDXW-1:0]  rd_idx    [2];
    logic             rd_hit    [2];
    logic [WIDTH-1:0] rd_data   [2];
    logic [WIDTH-1:0] cap_value [2];
    logic             hold_hit  [2];
    logic [WIDTH-1:0] hold_data [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [WIDTH:0] rd_snoop;
            logic [WIDTH:0] cap_snoop;
            logic [WIDTH:0] hold_snoop;

            // A stalled S1 keeps re-reading its own indices so the file
            // data stays current; otherwise the file follows decode.
            assign rd_idx[gi] = (s1_valid_q && !advance) ? s1_idx_q[gi]
                                                         : req_idx[gi];

            // Write landing on the edge that samples the read index: the
            // file will return the old value, so remember the new one.
            assign rd_snoop    = snoop_lookup(rd_idx[gi],
                                              write_enable0_i, reg_write_index0_i, value0_i,
                                              write_enable1_i, reg_write_index1_i, value1_i);
            assign rd_hit[gi]  = rd_snoop[WIDTH];
            assign rd_data[gi] = rd_snoop[WIDTH-1:0];

            // Value loaded into S2: a write at this very edge beats the
            // remembered forward, which beats the file data.
            assign cap_snoop     = snoop_lookup(s1_idx_q[gi],
                                                write_enable0_i, reg_write_index0_i, value0_i,
                                                write_enable1_i, reg_write_index1_i, value1_i);
            assign cap_value[gi] = cap_snoop[WIDTH] ? cap_snoop[WIDTH-1:0] :
                                   fwd_q[gi]        ? fwd_data_q[gi]       :
                                                      rf_value[gi];

            // Keeps a pair that execute has not taken yet up to date.
            assign hold_snoop    = snoop_lookup(s2_idx_q[gi],
                                                write_enable0_i, reg_write_index0_i, value0_i,
                                                write_enable1_i, reg_write_index1_i, value1_i);
            assign hold_hit[gi]  = hold_snoop[WIDTH];
            assign hold_data[gi] = hold_snoop[WIDTH-1:0];
        end
    endgenerate

    assign reg_read_index0_o = rd_idx[0];
    assign reg_read_index1_o = rd_idx[1];

    // S1 next state: load on accept, replay-capture while stalled, else drain
    always_comb begin
        s1_valid_d = s1_valid_q;
        for (int k = 0; k < 2; k++) begin
            s1_idx_d[k]   = s1_idx_q[k];
            fwd_d[k]      = fwd_q[k];
            fwd_data_d[k] = fwd_data_q[k];
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            for (int k = 0; k < 2; k++) begin
                s1_idx_d[k]   = req_idx[k];
                fwd_d[k]      = rd_hit[k];
                fwd_data_d[k] = rd_data[k];
            end
        end else if (s1_valid_q && !advance) begin
            for (int k = 0; k < 2; k++) begin
                fwd_d[k]      = rd_hit[k];
                fwd_data_d[k] = rd_data[k];
            end
        end else begin
            s1_valid_d = 1'b0;
            for (int k = 0; k < 2; k++) begin
                fwd_d[k] = 1'b0;
            end
        end
    end

    // S2 next state: capture on advance, refresh while held, drop on consume
    always_comb begin
        op_valid_d = op_valid_q;
        for (int k = 0; k < 2; k++) begin
            op_d[k]     = op_q[k];
            s2_idx_d[k] = s2_idx_q[k];
        end
        if (advance) begin
            op_valid_d = 1'b1;
            for (int k = 0; k < 2; k++) begin
                op_d[k]     = cap_value[k];
                s2_idx_d[k] = s1_idx_q[k];
            end
        end else if (op_valid_q && !op_ready_i) begin
            for (int k = 0; k < 2; k++) begin
                if (hold_hit[k]) begin
                    op_d[k] = hold_data[k];
                end
            end
        end else begin
            op_valid_d = 1'b0;
        end
    end

    // Scoreboard next state: writes clear, a reservation at the same edge wins
    always_comb begin
        busy_d = busy_q;
        if (write_enable0_i) begin
            busy_d[reg_write_index0_i] = 1'b0;
        end
        if (write_enable1_i) begin
            busy_d[reg_write_index1_i] = 1'b0;
        end
        if (mark_busy_i) begin
            busy_d[mark_busy_index_i] = 1'b1;
        end
    end

    // State registers; reset drops anything in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            op_valid_q <= 1'b0;
            busy_q     <= '0;
            for (int k = 0; k < 2; k++) begin
                s1_idx_q[k]   <= '0;
                fwd_q[k]      <= 1'b0;
                fwd_data_q[k] <= '0;
                op_q[k]       <= '0;
                s2_idx_q[k]   <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
            for (int k = 0; k < 2; k++) begin
                s1_idx_q[k]   <= s1_idx_d[k];
                fwd_q[k]      <= fwd_d[k];
                fwd_data_q[k] <= fwd_data_d[k];
                op_q[k]       <= op_d[k];
                s2_idx_q[k]   <= s2_idx_d[k];
            end
        end
    end

    assign op_valid_o = op_valid_q;
    assign opa_o      = op_q[0];
    assign opb_o      = op_q[1];
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Directed bench for cpu_operand_fetch with a registered-read register file model.
module tb_cpu_operand_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_ra_i = '0;
    logic [3:0]  req_rb_i = '0;
    logic        req_use_ra_i = 1'b0;
    logic        req_use_rb_i = 1'b0;
    logic        mark_busy_i = 1'b0;
    logic [3:0]  mark_busy_index_i = '0;
    logic        write_enable0_i = 1'b0;
    logic [3:0]  reg_write_index0_i = '0;
    logic [31:0] value0_i = '0;
    logic        write_enable1_i = 1'b0;
    logic [3:0]  reg_write_index1_i = '0;
    logic [31:0] value1_i = '0;
    logic [3:0]  reg_read_index0_o;
    logic [3:0]  reg_read_index1_o;
    logic [31:0] rf_value0_i;
    logic [31:0] rf_value1_i;
    logic        op_valid_o;
    logic        op_ready_i = 1'b1;
    logic [31:0] opa_o;
    logic [31:0] opb_o;
    logic [15:0] busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    cpu_operand_fetch #(.WIDTH(32), .NREGS(16), .IDXW(4)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_ra_i           (req_ra_i),
        .req_rb_i           (req_rb_i),
        .req_use_ra_i       (req_use_ra_i),
        .req_use_rb_i       (req_use_rb_i),
        .mark_busy_i        (mark_busy_i),
        .mark_busy_index_i  (mark_busy_index_i),
        .write_enable0_i    (write_enable0_i),
        .reg_write_index0_i (reg_write_index0_i),
        .value0_i           (value0_i),
        .write_enable1_i    (write_enable1_i),
        .reg_write_index1_i (reg_write_index1_i),
        .value1_i           (value1_i),
        .reg_read_index0_o  (reg_read_index0_o),
        .reg_read_index1_o  (reg_read_index1_o),
        .rf_value0_i        (rf_value0_i),
        .rf_value1_i        (rf_value1_i),
        .op_valid_o         (op_valid_o),
        .op_ready_i         (op_ready_i),
        .opa_o              (opa_o),
        .opb_o              (opb_o),
        .busy_o             (busy_o)
    );

    // Register file model: registered reads see the pre-write contents,
    // port 1 lands last on a same-index double write.
    logic [31:0] rf [16];
    logic        rf_load = 1'b1;

    function automatic logic [31:0] rf_init(input int i);
        if (i == 3) return 32'h11;
        if (i == 5) return 32'h22;
        return 32'h1000 + 32'(i);
    endfunction

    always @(posedge clk_i) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_init(i);
        end else begin
            rf_value0_i <= rf[reg_read_index0_o];
            rf_value1_i <= rf[reg_read_index1_o];
            if (write_enable0_i) rf[reg_write_index0_i] <= value0_i;
            if (write_enable1_i) rf[reg_write_index1_i] <= value1_i;
        end
    end

    typedef struct {
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        wedge;   // 0: writes at accept edge, 1: at capture edge
        logic        we0;
        logic [3:0]  wi0;
        logic [31:0] wv0;
        logic        we1;
        logic [3:0]  wi1;
        logic [31:0] wv1;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] ra, input logic [3:0] rb, input logic wedge,
                                input logic we0, input logic [3:0] wi0, input logic [31:0] wv0,
                                input logic we1, input logic [3:0] wi1, input logic [31:0] wv1,
                                input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.ra = ra; v.rb = rb; v.wedge = wedge;
        v.we0 = we0; v.wi0 = wi0; v.wv0 = wv0;
        v.we1 = we1; v.wi1 = wi1; v.wv1 = wv1;
        v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive_writes(input vec_t v);
        write_enable0_i = v.we0; reg_write_index0_i = v.wi0; value0_i = v.wv0;
        write_enable1_i = v.we1; reg_write_index1_i = v.wi1; value1_i = v.wv1;
    endtask

    task automatic clear_writes();
        write_enable0_i = 1'b0;
        write_enable1_i = 1'b0;
    endtask

    // One request through the pipe with op_ready_i high.
    task automatic apply_vec(input vec_t v, input int n);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_ra_i = v.ra; req_rb_i = v.rb;
        req_use_ra_i = 1'b1; req_use_rb_i = 1'b1;
        if (!v.wedge) drive_writes(v);
        #1 check("vec_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        clear_writes();
        if (v.wedge) drive_writes(v);
        #1 check("vec_bubble", 32'(op_valid_o), 32'd0);
        @(negedge clk_i);
        clear_writes();
        #1;
        check("vec_valid", 32'(op_valid_o), 32'd1);
        check("vec_opa", opa_o, v.exp_a);
        check("vec_opb", opb_o, v.exp_b);
        check("vec_busy", 32'(busy_o), 32'd0);
        $display("vec %0d ra=%0d rb=%0d opa=%h opb=%h", n, v.ra, v.rb, opa_o, opb_o);
        @(negedge clk_i);
        #1 check("vec_drain", 32'(op_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [9];
        vec_t v;
        logic [31:0] hold_exp_a [3];
        logic [31:0] hold_exp_b [3];
        logic [3:0]  hold_ra [3];
        logic [3:0]  hold_rb [3];
        int req_n;
        int out_n;

        vecs[0] = mk(4'd3, 4'd5, 1'b0, 1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    32'h11,   32'h22);
        vecs[1] = mk(4'd4, 4'd5, 1'b0, 1'b1, 4'd4, 32'hAAAA, 1'b0, 4'd0, 32'h0,    32'hAAAA, 32'h22);
        vecs[2] = mk(4'd2, 4'd2, 1'b0, 1'b1, 4'd2, 32'h10,   1'b1, 4'd2, 32'h20,   32'h20,   32'h20);
        vecs[3] = mk(4'd6, 4'd4, 1'b0, 1'b1, 4'd4, 32'hCCCC, 1'b1, 4'd6, 32'hBEEF, 32'hBEEF, 32'hCCCC);
        vecs[4] = mk(4'd4, 4'd6, 1'b0, 1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    32'hCCCC, 32'hBEEF);
        vecs[5] = mk(4'd0, 4'd15,1'b0, 1'b1, 4'd9, 32'h9,    1'b0, 4'd0, 32'h0,    32'h1000, 32'h100F);
        vecs[6] = mk(4'd2, 4'd3, 1'b1, 1'b1, 4'd2, 32'h1,    1'b1, 4'd2, 32'h2,    32'h2,    32'h11);
        vecs[7] = mk(4'd3, 4'd7, 1'b1, 1'b1, 4'd7, 32'h7777, 1'b0, 4'd0, 32'h0,    32'h11,   32'h7777);
        vecs[8] = mk(4'd7, 4'd7, 1'b0, 1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    32'h7777, 32'h7777);

        // Reset and file preload
        @(negedge clk_i);
        @(negedge clk_i);
        rf_load = 1'b0;
        rst_i   = 1'b0;
        #1;
        check("rst_valid", 32'(op_valid_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_opa",   opa_o, 32'd0);
        check("rst_opb",   opb_o, 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd1);

        for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

        // Scoreboard stall on r7, released by a port-1 write
        @(negedge clk_i);
        mark_busy_i = 1'b1; mark_busy_index_i = 4'd7;
        @(negedge clk_i);
        mark_busy_i = 1'b0;
        req_valid_i = 1'b1; req_ra_i = 4'd7; req_rb_i = 4'd0;
        req_use_ra_i = 1'b1; req_use_rb_i = 1'b1;
        write_enable1_i = 1'b1; reg_write_index1_i = 4'd7; value1_i = 32'h77;
        #1;
        check("sb_busy7", 32'(busy_o), 32'h80);
        check("sb_stall", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        clear_writes();
        #1;
        check("sb_cleared", 32'(busy_o), 32'd0);
        check("sb_ready",   32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1 check("sb_bubble", 32'(op_valid_o), 32'd0);
        @(negedge clk_i);
        #1;
        check("sb_valid", 32'(op_valid_o), 32'd1);
        check("sb_opa",   opa_o, 32'h77);
        check("sb_opb",   opb_o, 32'h1000);
        $display("scoreboard stall ra=7 opa=%h opb=%h", opa_o, opb_o);

        // Same busy register but source A not used: no stall
        @(negedge clk_i);
        mark_busy_i = 1'b1; mark_busy_index_i = 4'd7;
        @(negedge clk_i);
        mark_busy_i = 1'b0;
        req_valid_i = 1'b1; req_ra_i = 4'd7; req_rb_i = 4'd0;
        req_use_ra_i = 1'b0; req_use_rb_i = 1'b1;
        #1;
        check("nouse_busy",  32'(busy_o), 32'h80);
        check("nouse_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("nouse_valid", 32'(op_valid_o), 32'd1);
        check("nouse_opa",   opa_o, 32'h77);
        $display("no-use request ra=7 opa=%h", opa_o);

        // Same-edge set and clear of r9 (set wins), r7 cleared by port 1
        @(negedge clk_i);
        mark_busy_i = 1'b1; mark_busy_index_i = 4'd9;
        write_enable0_i = 1'b1; reg_write_index0_i = 4'd9; value0_i = 32'h99;
        write_enable1_i = 1'b1; reg_write_index1_i = 4'd7; value1_i = 32'h77;
        @(negedge clk_i);
        mark_busy_i = 1'b0;
        clear_writes();
        #1 check("sb_set_wins", 32'(busy_o), 32'h200);
        // Re-mark an already busy register, then clear it
        @(negedge clk_i);
        mark_busy_i = 1'b1; mark_busy_index_i = 4'd9;
        @(negedge clk_i);
        mark_busy_i = 1'b0;
        #1 check("sb_remark", 32'(busy_o), 32'h200);
        write_enable0_i = 1'b1; reg_write_index0_i = 4'd9; value0_i = 32'h99;
        @(negedge clk_i);
        clear_writes();
        #1 check("sb_all_clear", 32'(busy_o), 32'd0);
        $display("scoreboard set/clear busy=%h", busy_o);

        // Back-to-back requests against a stalled consumer, r1 refreshed in S2
        hold_ra[0] = 4'd1; hold_rb[0] = 4'd3; hold_exp_a[0] = 32'h55; hold_exp_b[0] = 32'h11;
        hold_ra[1] = 4'd5; hold_rb[1] = 4'd3; hold_exp_a[1] = 32'h22; hold_exp_b[1] = 32'h11;
        hold_ra[2] = 4'd3; hold_rb[2] = 4'd5; hold_exp_a[2] = 32'h11; hold_exp_b[2] = 32'h22;
        req_n = 0;
        out_n = 0;
        req_use_ra_i = 1'b1; req_use_rb_i = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk_i);
            op_ready_i = (cyc >= 5);
            if (cyc == 3) begin
                write_enable0_i = 1'b1; reg_write_index0_i = 4'd1; value0_i = 32'h55;
            end else begin
                clear_writes();
            end
            req_valid_i = (req_n < 3);
            if (req_n < 3) begin
                req_ra_i = hold_ra[req_n];
                req_rb_i = hold_rb[req_n];
            end
            #1;
            if (op_valid_o && op_ready_i) begin
                if (out_n < 3) begin
                    check("hold_opa", opa_o, hold_exp_a[out_n]);
                    check("hold_opb", opb_o, hold_exp_b[out_n]);
                    $display("hold pair %0d opa=%h opb=%h", out_n, opa_o, opb_o);
                end
                out_n++;
            end
            if (req_valid_i && req_ready_o) req_n++;
        end
        req_valid_i = 1'b0;
        check("hold_req_count", 32'(req_n), 32'd3);
        check("hold_out_count", 32'(out_n), 32'd3);

        // Asynchronous reset mid-stream
        @(negedge clk_i);
        op_ready_i = 1'b0;
        mark_busy_i = 1'b1; mark_busy_index_i = 4'd0;
        req_valid_i = 1'b1; req_ra_i = 4'd3; req_rb_i = 4'd5;
        #1 check("ar_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        mark_busy_index_i = 4'd7;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        mark_busy_i = 1'b0;
        #1;
        check("ar_pre_busy",  32'(busy_o), 32'h81);
        check("ar_pre_valid", 32'(op_valid_o), 32'd1);
        check("ar_pre_opa",   opa_o, 32'h11);
        #2 rst_i = 1'b1;
        #1;
        check("ar_valid", 32'(op_valid_o), 32'd0);
        check("ar_busy",  32'(busy_o), 32'd0);
        check("ar_opa",   opa_o, 32'd0);
        check("ar_opb",   opb_o, 32'd0);
        $display("async reset valid=%0d busy=%h", op_valid_o, busy_o);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        op_ready_i = 1'b1;
        v = mk(4'd3, 4'd5, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h11, 32'h22);
        apply_vec(v, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
